mux_arb_4rr: RTL

- Round-robin arbiter that shares one 4:1 one-bit select path between four requesters.
- Drives the sel1/sel0 lines of the 4:1 selector and a one-hot grant vector back to the requesters.
- Enforces a maximum tenure per grant and inserts a one-cycle dead turnaround between owners, so a select change never coincides with an active grant.
- Sits between the requesting units and the shared 4:1 one-bit selector on the 4-bit CPU datapath.

---
 rtl/mux_arb_4rr.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_arb_4rr.sv
// Round-robin arbiter for a shared 4:1 one-bit select path.
// Grants are capped in tenure while others wait, with a dead TURN cycle between owners.
module mux_arb_4rr #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       sel1,
  output logic       sel0,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state, state_n;
  logic [1:0]          sel_q, sel_n;
  logic [1:0]          last_q, last_n;
  logic [HOLD_W-1:0]   cnt_q, cnt_n;
  logic [3:0]          gnt_n;
  logic                pre_n;
  logic [1:0]          win;
  logic                timeout;

  // Scan from last+1 cyclically; descending loop so the earliest hit overwrites.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = last + 2'd1;
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign win     = rr_pick(last_q, req);
  assign timeout = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD - 1)) && |(req & ~gnt);

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    gnt_n   = gnt;
    pre_n   = 1'b0;
    case (state)
      IDLE, TURN: begin
        gnt_n   = 4'b0000;
        state_n = IDLE;
        if (|req) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // Release wins over timeout, so preempt only fires on a live owner.
        if (!req[sel_q]) begin
          gnt_n   = 4'b0000;
          last_n  = sel_q;
          state_n = TURN;
        end else if (timeout) begin
          gnt_n   = 4'b0000;
          last_n  = sel_q;
          pre_n   = 1'b1;
          state_n = TURN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt     <= 4'b0000;
      preempt <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      gnt     <= gnt_n;
      preempt <= pre_n;
      busy    <= (state_n != IDLE);
    end
  end

  assign sel1 = sel_q[1];
  assign sel0 = sel_q[0];

endmodule
